// File: rtl/nx_library_pkg.sv
// Shared nx_library package: read-side FSM state encoding
// and credit-counter width used by the FIFO credit reader.
package nx_library;

    localparam int CNT_W = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/nx_fifo_credit_rd_credit_cnt.sv
// nx_credit_cnt: downstream credit counter with saturation at
// CREDITS and a one-cycle overflow pulse on illegal returns.
// Ports: clk, rst (async high), run (FSM in RUN), flush,
//   load (initial grant), pop, ret -> cnt, ovf.
import nx_library::*;

module nx_credit_cnt #(
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             flush,
    input  logic             load,
    input  logic             pop,
    input  logic             ret,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CMAX = CNT_W'(CREDITS);

    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;

    always_comb begin
        cnt_d = cnt;
        ovf_d = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else if (!run) begin
            // returns while idle have nowhere to go
            ovf_d = ret;
            if (load) cnt_d = CMAX;
        end else if (pop && !ret) begin
            cnt_d = cnt - 1'b1;
        end else if (ret && !pop) begin
            if (cnt == CMAX) ovf_d = 1'b1;
            else             cnt_d = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_d;
            ovf <= ovf_d;
        end
    end

endmodule

// File: rtl/nx_fifo_credit_rd.sv
// Credit-gated reader: pops an upstream FIFO while downstream
// credits remain and presents each word registered, 1-cycle late.
// Ports: clk, rst, fifo_empty/fifo_rdata/fifo_ren (upstream),
//   credit_init, credit_ret, flush (control), out_valid/out_data
//   (downstream), credit_cnt, credit_ovf (status).
import nx_library::*;

module nx_fifo_credit_rd #(
    parameter int WIDTH   = 71,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    input  logic             credit_init,
    input  logic             credit_ret,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             credit_ovf
);

    rd_state_e state_q;
    rd_state_e state_d;
    logic      run;
    logic      pop;

    assign run = (state_q == ST_RUN);

    // credit gate makes counter underflow impossible
    assign pop = run && !fifo_empty
                 && (credit_cnt != '0) && !flush;
    assign fifo_ren = pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)                  state_d = ST_INIT;
        else if (!run && credit_init) state_d = ST_RUN;
    end

    nx_credit_cnt #(
        .CREDITS (CREDITS)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .flush (flush),
        .load  (credit_init),
        .pop   (pop),
        .ret   (credit_ret),
        .cnt   (credit_cnt),
        .ovf   (credit_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= pop;
            if (pop) out_data <= fifo_rdata;
        end
    end

endmodule

// File: tb/tb_nx_fifo_credit_rd.sv
// Directed + random bench for nx_fifo_credit_rd with an upstream
// FIFO model, a credit model and an output-word scoreboard.
module tb_nx_fifo_credit_rd;

    localparam int W  = 71;
    localparam int CR = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [W-1:0] fifo_rdata;
    logic         fifo_ren;
    logic         credit_init;
    logic         credit_ret;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [3:0]   credit_cnt;
    logic         credit_ovf;

    nx_fifo_credit_rd #(
        .WIDTH   (W),
        .CREDITS (CR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_ren    (fifo_ren),
        .credit_init (credit_init),
        .credit_ret  (credit_ret),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .credit_cnt  (credit_cnt),
        .credit_ovf  (credit_ovf)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] fq[$];
    logic [W-1:0] sb[$];
    logic         gate;
    int           mcnt;
    bit           mrun;
    logic [W-1:0] last;
    int           pulses;
    int           held;
    int           max_held;

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    task automatic fifo_upd();
        fifo_empty = gate || (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // one clock: drive at negedge, check ren before the edge,
    // check registered outputs just after it
    task automatic step(input bit i, input bit r, input bit f);
        bit           eren;
        bit           eovf;
        logic [W-1:0] w;
        credit_init = i;
        credit_ret  = r;
        flush       = f;
        fifo_upd();
        #1;
        eren = mrun && !fifo_empty && (mcnt != 0) && !f;
        chk("fifo_ren", W'(fifo_ren), W'(eren));
        if (fifo_ren) begin
            chk("ren_while_empty", W'(fifo_empty), '0);
            if (fq.size() != 0) begin
                w = fq.pop_front();
                sb.push_back(w);
                held++;
            end
        end
        eovf = 1'b0;
        if (f) begin
            mrun = 1'b0;
            mcnt = 0;
        end else if (!mrun) begin
            eovf = r;
            if (i) begin
                mrun = 1'b1;
                mcnt = CR;
            end
        end else begin
            if (r) held--;
            if (eren && !r) begin
                mcnt--;
            end else if (r && !eren) begin
                if (mcnt == CR) eovf = 1'b1;
                else            mcnt++;
            end
        end
        if (held > max_held) max_held = held;
        @(posedge clk);
        #1;
        chk("credit_cnt", W'(credit_cnt), W'(mcnt));
        chk("credit_ovf", W'(credit_ovf), W'(eovf));
        if (out_valid) pulses++;
        if (sb.size() != 0) begin
            chk("out_valid", W'(out_valid), W'(1));
            w = sb.pop_front();
            chk("out_data", out_data, w);
            last = w;
        end else begin
            chk("out_valid_idle", W'(out_valid), '0);
            chk("out_data_hold", out_data, last);
        end
        fifo_upd();
        @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ren"},   W'(fifo_ren), '0);
        chk({tag, "_valid"}, W'(out_valid), '0);
        chk({tag, "_data"},  out_data, '0);
        chk({tag, "_cnt"},   W'(credit_cnt), '0);
        chk({tag, "_ovf"},   W'(credit_ovf), '0);
    endtask

    initial begin
        bit r;
        rst = 1'b1;
        credit_init = 1'b0;
        credit_ret  = 1'b0;
        flush       = 1'b0;
        gate = 1'b0;
        mrun = 1'b0;
        mcnt = 0;
        last = '0;
        pulses = 0;
        held = 0;
        max_held = 0;
        fifo_upd();
        #1;
        chk_reset_outs("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // six words, four credits: four back-to-back pulses
        for (int k = 0; k < 6; k++) fq.push_back(rnd_word());
        step(1'b1, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b0);
        chk("s1_pulses", W'(pulses), W'(4));
        chk("s1_cnt", W'(credit_cnt), '0);
        chk("s1_left", W'(fq.size()), W'(2));
        #1;
        chk("s1_ren_low", W'(fifo_ren), '0);

        // single return at zero credits -> exactly one word
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("s2_pulses", W'(pulses), W'(5));
        chk("s2_cnt", W'(credit_cnt), '0);

        // saturation with empty FIFO, then pop+ret at full
        gate = 1'b1;
        repeat (4) step(1'b0, 1'b1, 1'b0);
        chk("s3_full", W'(credit_cnt), W'(4));
        step(1'b0, 1'b1, 1'b0);
        chk("s3_ovf", W'(credit_ovf), W'(1));
        chk("s3_sat", W'(credit_cnt), W'(4));
        step(1'b0, 1'b0, 1'b0);
        chk("s3_ovf_once", W'(credit_ovf), '0);
        gate = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk("s3_popret_cnt", W'(credit_cnt), W'(4));
        chk("s3_popret_ovf", W'(credit_ovf), '0);

        // flush beats ret/pop; init ignored in RUN
        for (int k = 0; k < 3; k++) fq.push_back(rnd_word());
        step(1'b0, 1'b0, 1'b0);
        gate = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk("s4_init_ign", W'(credit_cnt), W'(3));
        gate = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        chk("s4_flush_cnt", W'(credit_cnt), '0);
        chk("s4_flush_vld", W'(out_valid), '0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("s4_init_ret_ovf", W'(credit_ovf), W'(1));

        // reset while streaming
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) fq.push_back(rnd_word());
        step(1'b0, 1'b0, 1'b0);
        credit_init = 1'b0;
        credit_ret  = 1'b0;
        flush       = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        sb.delete();
        mrun = 1'b0;
        mcnt = 0;
        last = '0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("s5_quiet", W'(pulses), '0);

        // random traffic
        step(1'b1, 1'b0, 1'b0);
        held = 0;
        max_held = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 8)
                fq.push_back(rnd_word());
            gate = ($urandom_range(0, 3) == 0);
            r = (held > 0) && ($urandom_range(0, 1) == 1);
            step(1'b0, r, 1'b0);
        end
        gate = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("rnd_sb_empty", W'(sb.size()), '0);
        chk("rnd_outstanding", W'(max_held <= CR), W'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
